codec_map_dec_output_reader: RTL

//  Read-side sequencer for the MAP decoder output RAM: on a start strobe, reads one decoded frame
//  of (ilen+1) words starting at ibase and emits it as a valid/ready stream with sop/eop framing.

---
 rtl/codec_map_dec_output_pkg.sv | 17 +
 rtl/codec_map_dec_output_reader_if.sv | 29 ++
 rtl/codec_map_dec_output_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/codec_map_dec_output_pkg.sv
// Shared framing types for the MAP decoder output RAM readers/writers.
// Read-sequencer state and per-word stream tag.
package codec_map_dec_output_pkg;

  typedef enum logic [1:0] {
    cIDLE,
    cREAD,
    cDRAIN
  } t_rd_state;

  typedef struct packed {
    logic val;
    logic sop;
    logic eop;
  } t_strm_tag;

endpackage

// File: rtl/codec_map_dec_output_reader_if.sv
// Valid/ready word stream with sop/eop framing.
// master drives the word, slave returns ready.
interface codec_map_dec_output_reader_if #(
  parameter int pDAT_W = 1
) ();

  logic              val;
  logic              sop;
  logic              eop;
  logic [pDAT_W-1:0] dat;
  logic              ready;

  modport master (
    output val,
    output sop,
    output eop,
    output dat,
    input  ready
  );

  modport slave (
    input  val,
    input  sop,
    input  eop,
    input  dat,
    output ready
  );

endinterface

// File: rtl/codec_map_dec_output_reader.sv
// Reads one decoded frame from the output RAM and streams it
// with sop/eop; backpressure stalls the RAM via its clkena.
module codec_map_dec_output_reader
  import codec_map_dec_output_pkg::*;
#(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 1,
  parameter int pLEN_W  = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pADDR_W-1:0] ibase,
  input  logic [pLEN_W-1:0]  ilen,
  output logic               obusy,
  output logic               odone,
  output logic               orclkena,
  output logic               oread,
  output logic [pADDR_W-1:0] oraddr,
  input  logic [pDAT_W-1:0]  irdata,
  codec_map_dec_output_reader_if.master ostrm
);

  t_rd_state          state;
  t_rd_state          state_nxt;
  logic [pLEN_W:0]    cnt;
  logic [pLEN_W:0]    cnt_nxt;
  logic [pADDR_W-1:0] base;
  logic [pADDR_W-1:0] base_nxt;
  logic [pLEN_W-1:0]  len;
  logic [pLEN_W-1:0]  len_nxt;
  t_strm_tag          tag;
  t_strm_tag          tag_nxt;
  logic               done_nxt;

  logic               pen;
  logic               adv;
  logic               issue;
  logic               last;
  logic [pLEN_W:0]    len_ext;

  // Pipeline advance and RAM-side address issue
  assign pen      = ~tag.val | ostrm.ready;
  assign adv      = iclkena & pen;
  assign issue    = (state == cREAD) & adv;
  assign len_ext  = {1'b0, len};
  assign last     = (cnt == len_ext);

  assign orclkena = adv;
  assign oread    = issue;
  assign oraddr   = (state == cREAD) ? base + pADDR_W'(cnt) : '0;
  assign obusy    = (state != cIDLE);

  assign ostrm.val = tag.val;
  assign ostrm.sop = tag.sop;
  assign ostrm.eop = tag.eop;
  assign ostrm.dat = irdata;

  // Next state: FSM, word counter and tag stage
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    base_nxt  = base;
    len_nxt   = len;
    tag_nxt   = tag;
    done_nxt  = odone;
    if (iclkena) begin
      done_nxt = 1'b0;
      if (pen) begin
        tag_nxt.val = issue;
        tag_nxt.sop = issue & (cnt == '0);
        tag_nxt.eop = issue & last;
      end
      unique case (state)
        cIDLE: begin
          if (istart) begin
            base_nxt  = ibase;
            len_nxt   = ilen;
            cnt_nxt   = '0;
            state_nxt = cREAD;
          end
        end
        cREAD: begin
          if (pen) begin
            cnt_nxt = cnt + (pLEN_W+1)'(1);
            if (last) state_nxt = cDRAIN;
          end
        end
        cDRAIN: begin
          if (odone)
            state_nxt = cIDLE;
          else if (tag.val & ostrm.ready & tag.eop)
            done_nxt = 1'b1;
        end
        default: state_nxt = cIDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state <= cIDLE;
      cnt   <= '0;
      base  <= '0;
      len   <= '0;
      tag   <= '0;
      odone <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      base  <= base_nxt;
      len   <= len_nxt;
      tag   <= tag_nxt;
      odone <= done_nxt;
    end
  end

endmodule
